// File: rtl/game_pkg.sv
// Shared game constants: coordinate width, sprite sizes and the player FSM state codes.
package game_pkg;

    localparam int COORD_W  = 10;

    // Sprite sizes shared with the renderer and the enemy-plane judge.
    localparam int PLANE_W  = 50;
    localparam int PLANE_H  = 50;
    localparam int BULLET_W = 10;
    localparam int BULLET_H = 10;

    // Player state codes; plain constants keep older modules that compare raw codes happy.
    typedef logic [1:0] state_t;
    localparam state_t ST_ALIVE     = 2'd0;
    localparam state_t ST_INVULN    = 2'd1;
    localparam state_t ST_BOOM      = 2'd2;
    localparam state_t ST_GAME_OVER = 2'd3;

endpackage

// File: rtl/aabb_overlap.sv
// Axis-aligned rectangle overlap test between rectangle A (the plane) and rectangle B
// (a bullet). Arithmetic is one bit wider than the coordinates so right/bottom edges
// near the screen limit never wrap. Touching edges do not count as overlap.
module aabb_overlap
#(
    parameter int A_W = game_pkg::PLANE_W,
    parameter int A_H = game_pkg::PLANE_H,
    parameter int B_W = game_pkg::BULLET_W,
    parameter int B_H = game_pkg::BULLET_H
)(
    input  logic [game_pkg::COORD_W-1:0] ax_i,
    input  logic [game_pkg::COORD_W-1:0] ay_i,
    input  logic [game_pkg::COORD_W-1:0] bx_i,
    input  logic [game_pkg::COORD_W-1:0] by_i,
    input  logic                         en_i,
    output logic                         hit_o
);
    import game_pkg::*;

    localparam int EW = COORD_W + 1;

    logic [EW-1:0] ax, ay, bx, by;

    assign ax = {1'b0, ax_i};
    assign ay = {1'b0, ay_i};
    assign bx = {1'b0, bx_i};
    assign by = {1'b0, by_i};

    assign hit_o = en_i
                 & (bx + EW'(B_W) > ax) & (bx < ax + EW'(A_W))
                 & (by + EW'(B_H) > ay) & (by < ay + EW'(A_H));

endmodule

// File: rtl/player_hit_judge.sv
// Player-plane versus enemy-bullet judge: clears bullets that hit, takes one life per
// hit cycle and sequences invulnerability, explosion and game-over for the renderer.
module player_hit_judge
#(
    parameter int N_BULLETS     = 4,
    parameter int PLANE_W       = game_pkg::PLANE_W,
    parameter int PLANE_H       = game_pkg::PLANE_H,
    parameter int BULLET_W      = game_pkg::BULLET_W,
    parameter int BULLET_H      = game_pkg::BULLET_H,
    parameter int START_LIVES   = 3,
    parameter int INVULN_FRAMES = 60,
    parameter int BOOM_FRAMES   = 30
)(
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   tick,
    input  logic [game_pkg::COORD_W-1:0]           pp_x,
    input  logic [game_pkg::COORD_W-1:0]           pp_y,
    input  logic [game_pkg::COORD_W*N_BULLETS-1:0] eb_x,
    input  logic [game_pkg::COORD_W*N_BULLETS-1:0] eb_y,
    input  logic [N_BULLETS-1:0]                   eb_en,
    input  logic                                   restart,
    output logic [N_BULLETS-1:0]                   eb_kill,
    output logic                                   hit,
    output logic [2:0]                             lives,
    output logic                                   invuln,
    output logic                                   plane_visible,
    output logic                                   boom,
    output logic                                   game_over
);
    import game_pkg::*;

    localparam int CW = COORD_W;

    logic [N_BULLETS-1:0] ovl;

    state_t               state_q, state_d;
    logic [2:0]           lives_q, lives_d;
    logic [7:0]           cnt_q,   cnt_d;
    logic [N_BULLETS-1:0] kill_q,  kill_d;
    logic                 hit_q,   hit_d;

    generate
        for (genvar i = 0; i < N_BULLETS; i++) begin : g_slot
            aabb_overlap #(
                .A_W (PLANE_W),
                .A_H (PLANE_H),
                .B_W (BULLET_W),
                .B_H (BULLET_H)
            ) u_ovl (
                .ax_i  (pp_x),
                .ay_i  (pp_y),
                .bx_i  (eb_x[i*CW +: CW]),
                .by_i  (eb_y[i*CW +: CW]),
                .en_i  (eb_en[i]),
                .hit_o (ovl[i])
            );
        end
    endgenerate

    // Next-state: collisions only matter in ALIVE; a tick landing on a hit is absorbed by
    // the fresh counter load, so the following state always lasts the full frame count.
    always_comb begin
        state_d = state_q;
        lives_d = lives_q;
        cnt_d   = cnt_q;
        kill_d  = '0;
        hit_d   = 1'b0;
        case (state_q)
            ST_ALIVE: begin
                if (|ovl) begin
                    kill_d = ovl;
                    hit_d  = 1'b1;
                    if (lives_q > 3'd1) begin
                        lives_d = lives_q - 3'd1;
                        cnt_d   = 8'(INVULN_FRAMES);
                        state_d = ST_INVULN;
                    end else begin
                        lives_d = 3'd0;
                        cnt_d   = 8'(BOOM_FRAMES);
                        state_d = ST_BOOM;
                    end
                end
            end
            ST_INVULN: begin
                if (tick) begin
                    cnt_d = cnt_q - 8'd1;
                    if (cnt_q == 8'd1) state_d = ST_ALIVE;
                end
            end
            ST_BOOM: begin
                if (tick) begin
                    cnt_d = cnt_q - 8'd1;
                    if (cnt_q == 8'd1) state_d = ST_GAME_OVER;
                end
            end
            default: begin
                if (restart) begin
                    lives_d = 3'(START_LIVES);
                    cnt_d   = 8'd0;
                    state_d = ST_ALIVE;
                end
            end
        endcase
    end

    // State, lives, frame counter and the one-cycle kill/hit pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_ALIVE;
            lives_q <= 3'(START_LIVES);
            cnt_q   <= 8'd0;
            kill_q  <= '0;
            hit_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            lives_q <= lives_d;
            cnt_q   <= cnt_d;
            kill_q  <= kill_d;
            hit_q   <= hit_d;
        end
    end

    assign eb_kill   = kill_q;
    assign hit       = hit_q;
    assign lives     = lives_q;
    assign invuln    = (state_q == ST_INVULN);
    assign boom      = (state_q == ST_BOOM);
    assign game_over = (state_q == ST_GAME_OVER);

    // Blink during invulnerability: counter bit 2 toggles every four ticks.
    assign plane_visible = (state_q == ST_INVULN) ? ~cnt_q[2] : (state_q != ST_GAME_OVER);

endmodule

// File: tb/tb_player_hit_judge.sv
// Bench for player_hit_judge: overlap edge table, hand-written life/state sequences and a
// randomized run, all checked against a frame-level model of the player's life cycle.
module tb_player_hit_judge;

    localparam int NB = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            tick = 1'b0;
    logic            restart = 1'b0;
    logic [9:0]      pp_x = '0;
    logic [9:0]      pp_y = '0;
    logic [10*NB-1:0] eb_x = '0;
    logic [10*NB-1:0] eb_y = '0;
    logic [NB-1:0]   eb_en = '0;
    logic [NB-1:0]   eb_kill;
    logic            hit;
    logic [2:0]      lives;
    logic            invuln, plane_visible, boom, game_over;

    player_hit_judge dut (
        .clk(clk), .rst(rst), .tick(tick), .pp_x(pp_x), .pp_y(pp_y),
        .eb_x(eb_x), .eb_y(eb_y), .eb_en(eb_en), .restart(restart),
        .eb_kill(eb_kill), .hit(hit), .lives(lives), .invuln(invuln),
        .plane_visible(plane_visible), .boom(boom), .game_over(game_over)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    // Model: phase 0 alive, 1 invulnerable, 2 exploding, 3 game over.
    int m_phase, m_lives, m_frames, m_kill, m_hit;

    typedef struct {
        int bx;
        int by;
        bit en;
        bit exp_hit;
    } vec_t;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic bit rect_hit(int px, int py, int bx, int by);
        return (bx + 10 > px) && (bx < px + 50) && (by + 10 > py) && (by < py + 50);
    endfunction

    task automatic model_reset();
        m_phase = 0; m_lives = 3; m_frames = 0; m_kill = 0; m_hit = 0;
    endtask

    task automatic model_step();
        int mask;
        mask = 0;
        for (int i = 0; i < NB; i++)
            if (eb_en[i] && rect_hit(int'(pp_x), int'(pp_y), int'(eb_x[i*10 +: 10]), int'(eb_y[i*10 +: 10])))
                mask |= (1 << i);
        m_kill = 0;
        m_hit  = 0;
        if (m_phase == 0) begin
            if (mask != 0) begin
                m_kill = mask;
                m_hit  = 1;
                m_lives = m_lives - 1;
                if (m_lives > 0) begin m_phase = 1; m_frames = 60; end
                else             begin m_phase = 2; m_frames = 30; end
            end
        end else if (m_phase == 1 || m_phase == 2) begin
            if (tick) begin
                m_frames = m_frames - 1;
                if (m_frames == 0) m_phase = m_phase + 1 - ((m_phase == 1) ? 2 : 0);
            end
        end else if (restart) begin
            m_phase = 0; m_lives = 3; m_frames = 0;
        end
    endtask

    task automatic check_all(input string tag);
        int vis;
        vis = (m_phase == 1) ? ((m_frames % 8) < 4 ? 1 : 0) : (m_phase == 3 ? 0 : 1);
        chk({tag, " eb_kill"}, int'(eb_kill), m_kill);
        chk({tag, " hit"}, int'(hit), m_hit);
        chk({tag, " lives"}, int'(lives), m_lives);
        chk({tag, " invuln"}, int'(invuln), (m_phase == 1) ? 1 : 0);
        chk({tag, " boom"}, int'(boom), (m_phase == 2) ? 1 : 0);
        chk({tag, " game_over"}, int'(game_over), (m_phase == 3) ? 1 : 0);
        chk({tag, " plane_visible"}, int'(plane_visible), vis);
    endtask

    task automatic cyc(input string tag, input bit t, input bit r);
        tick = t;
        restart = r;
        model_step();
        @(posedge clk);
        #1;
        tick = 1'b0;
        restart = 1'b0;
        check_all(tag);
    endtask

    task automatic set_b(input int slot, input int x, input int y, input bit en);
        eb_x[slot*10 +: 10] = 10'(x);
        eb_y[slot*10 +: 10] = 10'(y);
        eb_en[slot] = en;
    endtask

    task automatic do_reset();
        rst = 1'b1; tick = 1'b0; restart = 1'b0; eb_en = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        check_all("reset");
    endtask

    vec_t vt[12];

    initial begin
        int guard;
        model_reset();

        // Overlap edges around plane (300,400)-(349,449), exercised through slot 1.
        vt[0]  = '{310, 420, 1, 1};  vt[1]  = '{290, 420, 1, 0};
        vt[2]  = '{291, 420, 1, 1};  vt[3]  = '{350, 420, 1, 0};
        vt[4]  = '{349, 420, 1, 1};  vt[5]  = '{310, 390, 1, 0};
        vt[6]  = '{310, 391, 1, 1};  vt[7]  = '{310, 450, 1, 0};
        vt[8]  = '{310, 449, 1, 1};  vt[9]  = '{310, 420, 0, 0};
        vt[10] = '{0, 0, 1, 0};      vt[11] = '{1023, 1023, 1, 0};
        for (int k = 0; k < 12; k++) begin
            do_reset();
            pp_x = 10'd300; pp_y = 10'd400;
            set_b(1, vt[k].bx, vt[k].by, vt[k].en);
            cyc("table", 1'b0, 1'b0);
            chk($sformatf("table[%0d] eb_kill", k), int'(eb_kill), vt[k].exp_hit ? 2 : 0);
            chk($sformatf("table[%0d] hit", k), int'(hit), vt[k].exp_hit ? 1 : 0);
        end

        // First hit, with an ignored restart in ALIVE beforehand.
        do_reset();
        pp_x = 10'd300; pp_y = 10'd400;
        cyc("restart_alive", 1'b0, 1'b1);
        chk("restart_alive lives", int'(lives), 3);
        set_b(0, 310, 420, 1'b1);
        cyc("first_hit", 1'b0, 1'b0);
        chk("first_hit eb_kill", int'(eb_kill), 1);
        chk("first_hit lives", int'(lives), 2);
        chk("first_hit invuln", int'(invuln), 1);
        cyc("hit_pulse_end", 1'b0, 1'b0);
        chk("hit_pulse_end hit", int'(hit), 0);

        // Double overlap costs one life; invulnerability lasts exactly 60 ticks.
        do_reset();
        set_b(0, 310, 420, 1'b1);
        set_b(2, 330, 440, 1'b1);
        cyc("double", 1'b0, 1'b0);
        chk("double eb_kill", int'(eb_kill), 5);
        chk("double lives", int'(lives), 2);
        for (int k = 0; k < 59; k++) cyc("inv_hold", 1'b1, 1'b0);
        chk("inv_59 invuln", int'(invuln), 1);
        cyc("inv_60", 1'b1, 1'b0);
        chk("inv_60 invuln", int'(invuln), 0);
        chk("inv_60 eb_kill", int'(eb_kill), 0);
        cyc("post_inv", 1'b0, 1'b0);
        chk("post_inv eb_kill", int'(eb_kill), 5);
        chk("post_inv lives", int'(lives), 1);

        // Last life: tick coincides with the hit, boom lasts 30 ticks, then restart.
        for (int k = 0; k < 60; k++) cyc("inv2", 1'b1, 1'b0);
        cyc("last_hit", 1'b1, 1'b0);
        chk("last_hit boom", int'(boom), 1);
        chk("last_hit lives", int'(lives), 0);
        for (int k = 0; k < 29; k++) cyc("boom_hold", 1'b1, 1'b0);
        chk("boom_29 boom", int'(boom), 1);
        cyc("boom_30", 1'b1, 1'b0);
        chk("boom_30 game_over", int'(game_over), 1);
        chk("boom_30 plane_visible", int'(plane_visible), 0);
        eb_en = '0;
        cyc("go_hold", 1'b1, 1'b0);
        cyc("restart", 1'b0, 1'b1);
        chk("restart lives", int'(lives), 3);
        chk("restart game_over", int'(game_over), 0);

        // Async reset in the middle of the explosion.
        do_reset();
        set_b(3, 320, 410, 1'b1);
        guard = 0;
        while (m_phase != 2 && guard < 500) begin
            cyc("to_boom", 1'b1, 1'b0);
            guard++;
        end
        chk("to_boom reached", (m_phase == 2) ? 1 : 0, 1);
        eb_en = '0;
        for (int k = 0; k < 10; k++) cyc("boom10", 1'b1, 1'b0);
        #2 rst = 1'b1;
        #1;
        chk("async_rst lives", int'(lives), 3);
        chk("async_rst boom", int'(boom), 0);
        chk("async_rst game_over", int'(game_over), 0);
        chk("async_rst invuln", int'(invuln), 0);
        chk("async_rst plane_visible", int'(plane_visible), 1);
        chk("async_rst eb_kill", int'(eb_kill), 0);
        chk("async_rst hit", int'(hit), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();

        // Randomized play against the model.
        for (int k = 0; k < 4000; k++) begin
            pp_x = 10'($urandom_range(0, 1023));
            pp_y = 10'($urandom_range(0, 1023));
            for (int i = 0; i < NB; i++) begin
                int bx, by;
                bx = int'(pp_x) + int'($urandom_range(0, 140)) - 70;
                by = int'(pp_y) + int'($urandom_range(0, 140)) - 70;
                if (bx < 0) bx = 0;
                if (bx > 1023) bx = 1023;
                if (by < 0) by = 0;
                if (by > 1023) by = 1023;
                set_b(i, bx, by, ($urandom_range(0, 3) == 0));
            end
            cyc("rand", ($urandom_range(0, 1) == 1), ($urandom_range(0, 5) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/player_hit_judge.md
Name: player_hit_judge

Overview:
- Collision/damage judge for the player plane versus enemy bullets; the enemy-fire counterpart of the enemy-plane hit judge.
- Compares up to N_BULLETS enemy-bullet positions against the player plane every cycle.
- Clears bullets that hit and decrements player lives.
- Sequences invulnerability, explosion and game-over states for the renderer and the game controller.

Parameters:
N_BULLETS, 4, number of enemy bullet slots checked in parallel
PLANE_W, 50, player plane width in pixels
PLANE_H, 50, player plane height in pixels
BULLET_W, 10, enemy bullet width in pixels
BULLET_H, 10, enemy bullet height in pixels
START_LIVES, 3, lives loaded at reset/restart (1..7)
INVULN_FRAMES, 60, frame ticks of invulnerability after a non-fatal hit (1..255)
BOOM_FRAMES, 30, frame ticks of explosion before game over (1..255)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
tick  in  1  one-cycle frame pulse (once per video frame)
pp_x  in  10  player plane left x, pixels
pp_y  in  10  player plane top y, pixels
eb_x  in  10*N_BULLETS  packed enemy bullet left x, slot i at [10i+9:10i]
eb_y  in  10*N_BULLETS  packed enemy bullet top y
eb_en  in  N_BULLETS  1 = bullet slot i active
restart  in  1  one-cycle pulse from game controller
eb_kill  out  N_BULLETS  one-cycle pulse per slot: clear that bullet
hit  out  1  one-cycle pulse on any life loss
lives  out  3  remaining lives
invuln  out  1  1 while in INVULN state
plane_visible  out  1  blink-aware draw enable for the player sprite
boom  out  1  1 while in BOOM state
game_over  out  1  1 while in GAME_OVER state

Behaviour:
- Reset values: state ALIVE, lives=START_LIVES, frame counter 0, eb_kill=0, hit=0, invuln=0, boom=0, game_over=0, plane_visible=1.
- Overlap test for slot i, combinational, in 11-bit unsigned arithmetic (no wrap):
  - condition: eb_en[i] & (bx+BULLET_W > pp_x) & (bx < pp_x+PLANE_W) & (by+BULLET_H > pp_y) & (by < pp_y+PLANE_H)
  - touching edges are not a hit.
- All outputs are registered. Inputs sampled at edge N produce eb_kill, hit and the state change at edge N+1 (1-cycle latency).
- ALIVE:
  - All overlapping slots get an eb_kill pulse simultaneously.
  - Any overlap causes exactly one life loss, regardless of how many slots overlap; hit pulses for one cycle.
  - lives>1: lives-=1, counter=INVULN_FRAMES, go to INVULN.
  - lives==1: lives=0, counter=BOOM_FRAMES, go to BOOM.
- INVULN:
  - Collisions ignored; eb_kill=0, bullets pass through.
  - Counter decrements on each tick. A tick with counter==1 returns to ALIVE, so exactly INVULN_FRAMES ticks elapse.
- BOOM:
  - No collision evaluation.
  - Counter decrements on tick. A tick with counter==1 goes to GAME_OVER.
- GAME_OVER: holds until restart. Restart sets lives=START_LIVES, counter 0, state ALIVE (takes effect at the next edge).
- restart outside GAME_OVER is ignored.
- tick in ALIVE has no effect.
- A tick coinciding with an overlap in ALIVE: the hit is taken and the counter loads the full value; the same tick is not counted.
- A tick and the final-count transition in INVULN: leave INVULN at that edge. An overlap on the following cycle is judged in ALIVE.
- plane_visible:
  - ALIVE=1
  - INVULN = ~counter[2] (blink every 4 ticks)
  - BOOM=1 (renderer swaps to explosion sprite via boom)
  - GAME_OVER=0
- Asserting rst mid-operation (any state, including mid-BOOM) returns to the reset values immediately.
- Position inputs are assumed stable within a cycle. No synchronisation is required; all inputs are in the clk domain.

Decomposition:
- Shared package (game_pkg):
  - state enum {ALIVE, INVULN, BOOM, GAME_OVER}
  - coordinate width constant (10)
  - the sprite size constants shared with the renderer and the enemy judge.
- Sub-module aabb_overlap: 11-bit rectangle overlap comparator, parameterised by both widths/heights, instantiated N_BULLETS times via generate.

Test Plan:
1. Reset, pp=(300,400), slot0 en at (310,420), others disabled -> edge+1: eb_kill=4'b0001, hit=1 for one cycle, lives=2, invuln=1.
2. Touching edge: slot1 at (250,400) (bx+10==pp_x-40... set bx=290) -> no eb_kill, lives unchanged; bx=291 -> hit.
3. Slots 0 and 2 overlap in the same cycle in ALIVE -> eb_kill=4'b0101, lives drop by exactly 1.
4. In INVULN keep slot0 overlapping -> eb_kill stays 0. After exactly 60 ticks invuln=0; on the next cycle the overlap hits, lives=1.
5. lives=1, hit -> boom=1, lives=0. After 30 ticks game_over=1, plane_visible=0. restart -> lives=3, ALIVE. A restart pulse issued earlier in ALIVE is ignored.
6. Assert rst during BOOM at tick 10 -> all outputs return to reset values; lives=3 immediately.
